// File: rtl/ifm_rd_skew_ctrl.sv
// Read-side controller for the ping-pong IFM FIFO array: clears the selected
// bank's read pointers, then issues a diagonally skewed read wavefront.
module ifm_rd_skew_ctrl #(
    parameter int NUM_FIFO          = 16,
    parameter int MAX_WGT_FIFO_SIZE = 4608,
    parameter int CNT_WIDTH         = 13
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] rd_len,
    input  logic [4:0]           num_lanes,
    input  logic                 buf_sel,
    output logic [NUM_FIFO-1:0]  rd_en_1,
    output logic [NUM_FIFO-1:0]  rd_en_2,
    output logic                 rd_clr_1,
    output logic                 rd_clr_2,
    output logic                 ifm_mux,
    output logic                 busy,
    output logic                 done
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CLR   = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam logic [CNT_WIDTH-1:0] MAX_LEN = CNT_WIDTH'(MAX_WGT_FIFO_SIZE);
    localparam logic [4:0]           FULL_N  = 5'(NUM_FIFO);

    logic [2:0]           state;
    logic [CNT_WIDTH-1:0] len_q;
    logic [4:0]           lanes_q;
    logic                 sel_q;
    logic [CNT_WIDTH-1:0] cnt;
    logic [NUM_FIFO-2:0]  skew_q;

    logic                 lane0;
    logic                 wave_on;
    logic [CNT_WIDTH-1:0] drain_last;
    logic [NUM_FIFO-1:0]  lane_mask;
    logic [NUM_FIFO-1:0]  en_vec;

    assign lane0      = (state == ST_READ);
    assign wave_on    = (state == ST_READ) || (state == ST_DRAIN);
    // DRAIN lasts N-1 cycles: the time for lane N-1 to catch up with lane 0.
    assign drain_last = {{(CNT_WIDTH-5){1'b0}}, lanes_q} - CNT_WIDTH'(2);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            len_q   <= '0;
            lanes_q <= '0;
            sel_q   <= 1'b0;
            cnt     <= '0;
            skew_q  <= '0;
        end else begin
            skew_q <= (state == ST_CLR) ? '0 : {skew_q[NUM_FIFO-3:0], lane0};
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q   <= (rd_len > MAX_LEN) ? MAX_LEN : rd_len;
                        lanes_q <= (num_lanes == 5'd0 || num_lanes > FULL_N) ? FULL_N : num_lanes;
                        sel_q   <= buf_sel;
                        state   <= ST_CLR;
                    end
                end
                ST_CLR: begin
                    cnt   <= '0;
                    state <= (len_q != '0) ? ST_READ : ST_DONE;
                end
                ST_READ: begin
                    if (cnt == len_q - CNT_WIDTH'(1)) begin
                        cnt   <= '0;
                        state <= (lanes_q == 5'd1) ? ST_DONE : ST_DRAIN;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                ST_DRAIN: begin
                    if (cnt == drain_last) begin
                        state <= ST_DONE;
                    end else begin
                        cnt <= cnt + CNT_WIDTH'(1);
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int i = 0; i < NUM_FIFO; i++) begin
            lane_mask[i] = (5'(i) < lanes_q);
        end
    end

    // Stale shift-register bits from a previous pass never leak outside READ/DRAIN.
    assign en_vec   = {skew_q, lane0} & lane_mask & {NUM_FIFO{wave_on}};
    assign rd_en_1  = sel_q ? '0 : en_vec;
    assign rd_en_2  = sel_q ? en_vec : '0;
    assign rd_clr_1 = (state == ST_CLR) && !sel_q;
    assign rd_clr_2 = (state == ST_CLR) && sel_q;
    assign ifm_mux  = sel_q;
    assign busy     = (state == ST_CLR) || wave_on;
    assign done     = (state == ST_DONE);

endmodule

// File: tb/tb_ifm_rd_skew_ctrl.sv
// Randomized scoreboard bench for ifm_rd_skew_ctrl; expected waveforms come
// from the pass timing rules evaluated per cycle.
module tb_ifm_rd_skew_ctrl;

    localparam int NF   = 16;
    localparam int MAXL = 4608;
    localparam int CW   = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] rd_len;
    logic [4:0]    num_lanes;
    logic          buf_sel;
    logic [NF-1:0] rd_en_1;
    logic [NF-1:0] rd_en_2;
    logic          rd_clr_1;
    logic          rd_clr_2;
    logic          ifm_mux;
    logic          busy;
    logic          done;

    ifm_rd_skew_ctrl #(
        .NUM_FIFO(NF),
        .MAX_WGT_FIFO_SIZE(MAXL),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .rd_len(rd_len),
        .num_lanes(num_lanes),
        .buf_sel(buf_sel),
        .rd_en_1(rd_en_1),
        .rd_en_2(rd_en_2),
        .rd_clr_1(rd_clr_1),
        .rd_clr_2(rd_clr_2),
        .ifm_mux(ifm_mux),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int k;
        int l;
        int n;
        bit sel;
    } pass_t;

    int    cyc = 0;
    int    errors = 0;
    int    checks = 0;
    pass_t expq[$];
    int    free_at = 0;
    bit    exp_mux = 1'b0;
    int    lane_cnt[NF];
    bit    mon_on = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc + 1, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int done_cycle(input pass_t p);
        return (p.l == 0) ? p.k + 2 : p.k + p.l + p.n + 1;
    endfunction

    // Drives a one-cycle start; the model alone decides whether the DUT should accept it.
    task automatic apply_stimulus(input int len, input int lanes, input bit sel);
        pass_t p;
        int    k;
        k         = cyc + 1;
        rd_len    = CW'(len);
        num_lanes = 5'(lanes);
        buf_sel   = sel;
        start     = 1'b1;
        if (k >= free_at) begin
            p.k   = k;
            p.l   = (len > MAXL) ? MAXL : len;
            p.n   = (lanes == 0 || lanes > NF) ? NF : lanes;
            p.sel = sel;
            for (int i = 0; i < NF; i++) lane_cnt[i] = 0;
            expq.push_back(p);
            free_at = done_cycle(p) + 1;
        end
        tick();
        start     = 1'b0;
        rd_len    = CW'($urandom());
        num_lanes = 5'($urandom());
        buf_sel   = 1'($urandom());
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        while (expq.size() > 0 && n < max_cyc) begin
            tick();
            n++;
        end
        check_output("pass_timeout", 32'(expq.size()), 32'd0);
        if (expq.size() > 0) expq.delete();
    endtask

    task automatic reset_mid();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        expq.delete();
        exp_mux = 1'b0;
        free_at = cyc + 1;
    endtask

    // Monitor: cycle c is the interval ending at edge c, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_on) begin
            pass_t         p;
            logic [NF-1:0] e1;
            logic [NF-1:0] e2;
            logic [NF-1:0] ev;
            logic          c1;
            logic          c2;
            logic          b;
            logic          d;
            int            c;
            int            dc;
            c  = cyc + 1;
            e1 = '0;
            e2 = '0;
            c1 = 1'b0;
            c2 = 1'b0;
            b  = 1'b0;
            d  = 1'b0;
            dc = 0;
            if (expq.size() > 0 && c >= expq[0].k + 1) begin
                p       = expq[0];
                dc      = done_cycle(p);
                exp_mux = p.sel;
                ev      = '0;
                for (int i = 0; i < NF; i++) begin
                    if (i < p.n && c >= p.k + 2 + i && c <= p.k + 1 + p.l + i) ev[i] = 1'b1;
                end
                if (p.sel) e2 = ev;
                else       e1 = ev;
                c1 = (c == p.k + 1) && !p.sel;
                c2 = (c == p.k + 1) && p.sel;
                b  = (c >= p.k + 1) && (c < dc);
                d  = (c == dc);
                for (int i = 0; i < NF; i++) begin
                    lane_cnt[i] += p.sel ? int'(rd_en_2[i] === 1'b1) : int'(rd_en_1[i] === 1'b1);
                end
            end
            check_output("rd_en_1", 32'(rd_en_1), 32'(e1));
            check_output("rd_en_2", 32'(rd_en_2), 32'(e2));
            check_output("rd_clr_1", 32'(rd_clr_1), 32'(c1));
            check_output("rd_clr_2", 32'(rd_clr_2), 32'(c2));
            check_output("busy", 32'(busy), 32'(b));
            check_output("done", 32'(done), 32'(d));
            check_output("ifm_mux", 32'(ifm_mux), 32'(exp_mux));
            if (d) begin
                for (int i = 0; i < NF; i++) begin
                    check_output($sformatf("lane%0d_count", i), 32'(lane_cnt[i]),
                                 32'((i < p.n) ? p.l : 0));
                end
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        int d;
        int len;
        rst       = 1'b1;
        start     = 1'b0;
        rd_len    = '0;
        num_lanes = '0;
        buf_sel   = 1'b0;
        repeat (3) tick();
        rst     = 1'b0;
        free_at = cyc + 1;
        mon_on  = 1'b1;

        apply_stimulus(4, 16, 1'b0);
        wait_idle(100);
        apply_stimulus(3, 3, 1'b1);
        wait_idle(100);
        apply_stimulus(0, 16, 1'b0);
        wait_idle(100);
        apply_stimulus(8191, 0, 1'b1);
        wait_idle(5000);

        // Starts during READ and during DONE must be ignored; the next one is accepted.
        apply_stimulus(20, 8, 1'b0);
        d = done_cycle(expq[0]);
        repeat (3) tick();
        apply_stimulus(7, 4, 1'b1);
        while (cyc < d - 1) tick();
        apply_stimulus(5, 2, 1'b1);
        apply_stimulus(6, 5, 1'b1);
        wait_idle(100);

        apply_stimulus(10, 16, 1'b0);
        repeat (5) tick();
        reset_mid();
        repeat (2) tick();
        apply_stimulus(10, 16, 1'b0);
        wait_idle(100);

        for (int it = 0; it < 40; it++) begin
            len = ($urandom_range(0, 12) == 0) ? int'($urandom_range(4590, 8191))
                                               : int'($urandom_range(0, 40));
            apply_stimulus(len, int'($urandom_range(0, 31)), 1'($urandom()));
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(0, 6)) tick();
                apply_stimulus(int'($urandom_range(0, 40)), int'($urandom_range(0, 31)), 1'($urandom()));
            end
            wait_idle(5000);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
